msrv_imm_gen_pipe: RTL

//  Parametrised, pipelined immediate generator with a valid/ready handshake.

---
 rtl/msrv_imm_gen_pipe.sv | 104 ++++++++++
 1 files changed

// File: rtl/msrv_imm_gen_pipe.sv
// RISC-V immediate generator with shamt mode, illegal-type flag and a
// 2-entry skid buffer (MAIN + SKID) behind a valid/ready handshake.
module msrv_imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             ms_riscv32_mp_clk_in,
    input  logic             ms_riscv32_mp_rst_in,
    input  logic             flush_in,
    input  logic             in_valid_in,
    output logic             in_ready_out,
    input  logic [24:0]      instr_in,
    input  logic [2:0]       imm_type_in,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid_out,
    input  logic             out_ready_in,
    output logic [XLEN-1:0]  imm_out,
    output logic [TAG_W-1:0] tag_out,
    output logic             illegal_out
);

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
        logic             ill;
    } ent_t;

    ent_t dec;
    ent_t main_q;
    ent_t skid_q;
    logic main_v;
    logic skid_v;
    logic acc;
    logic held;

    // instr_in[k] carries instruction bit k+7
    always_comb begin
        dec     = '0;
        dec.tag = tag_in;
        case (imm_type_in)
            3'b000, 3'b001:
                dec.imm = XLEN'($signed(instr_in[24:13]));
            3'b010:
                dec.imm = XLEN'($signed({instr_in[24:18], instr_in[4:0]}));
            3'b011:
                dec.imm = XLEN'($signed({instr_in[24], instr_in[0],
                                          instr_in[23:18], instr_in[4:1],
                                          1'b0}));
            3'b100:
                dec.imm = XLEN'($signed({instr_in[24:5], 12'h000}));
            3'b101:
                dec.imm = XLEN'($signed({instr_in[24], instr_in[12:5],
                                          instr_in[13], instr_in[23:14],
                                          1'b0}));
            3'b110:
                dec.imm = XLEN'(instr_in[12:8]);
            default: begin
                if (XLEN == 64) begin
                    dec.imm = XLEN'(instr_in[18:13]);
                end else begin
                    dec.imm = XLEN'(instr_in[17:13]);
                    dec.ill = instr_in[18];
                end
            end
        endcase
    end

    assign in_ready_out = !skid_v;
    assign acc          = in_valid_in && !skid_v;
    assign held         = main_v && !out_ready_in;

    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush_in) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (held) begin
            if (acc) begin
                skid_q <= dec;
                skid_v <= 1'b1;
            end
        end else if (skid_v) begin
            // in_ready_out was low, so no input competes with the refill
            main_q <= skid_q;
            main_v <= 1'b1;
            skid_v <= 1'b0;
        end else if (acc) begin
            main_q <= dec;
            main_v <= 1'b1;
        end else begin
            main_v <= 1'b0;
        end
    end

    assign out_valid_out = main_v;
    assign imm_out       = main_q.imm;
    assign tag_out       = main_q.tag;
    assign illegal_out   = main_q.ill;

endmodule
